axis_conv_input_slice: RTL and testbench

//  Full-throughput two-entry register slice that consumes the merged pixels/weights/tuser stream from the input pipe and feeds the conv engine.
//  It breaks the long combinational ready path: input tready depends only on registered state.
//  It also latches config-beat fields and counts the beats in each tlast-delimited frame, for status and debug.

---
 rtl/axis_conv_input_slice.sv | 88 ++++++++
 tb/tb_axis_conv_input_slice.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axis_conv_input_slice.sv
// axis_conv_input_slice: two-entry full-throughput register slice feeding the conv engine
// Ports:
//   aclk, areset                        clock and synchronous active-high reset
//   s_axis_* / s_pixels_* / s_weights    input beat (tready depends on registered state only)
//   m_axis_* / m_pixels_* / m_weights    registered output beat
//   cfg_kernel_w_1                      kernel_w-1 of the last accepted config beat
//   frame_beats, frame_done             beat count of the last completed frame and its pulse
//   err_valid_drop                      sticky flag: tvalid withdrawn while stalled
module axis_conv_input_slice #(
  parameter int UNITS         = 8,
  parameter int CORES         = 4,
  parameter int MEMBERS       = 12,
  parameter int WORD_WIDTH    = 8,
  parameter int TUSER_WIDTH   = 16,
  parameter int I_IS_CONFIG   = 7,
  parameter int I_KERNEL_W_1  = 12,
  parameter int BITS_KERNEL_W = 2,
  parameter int BITS_BEATS    = 20
)(
  input  logic                                  aclk,
  input  logic                                  areset,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
  input  logic [WORD_WIDTH*UNITS-1:0]           s_pixels_1,
  input  logic [WORD_WIDTH*UNITS-1:0]           s_pixels_2,
  input  logic [WORD_WIDTH*CORES*MEMBERS-1:0]   s_weights,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic [WORD_WIDTH*UNITS-1:0]           m_pixels_1,
  output logic [WORD_WIDTH*UNITS-1:0]           m_pixels_2,
  output logic [WORD_WIDTH*CORES*MEMBERS-1:0]   m_weights,
  output logic [BITS_KERNEL_W-1:0]              cfg_kernel_w_1,
  output logic [BITS_BEATS-1:0]                 frame_beats,
  output logic                                  frame_done,
  output logic                                  err_valid_drop
);
  localparam int W_PIX = WORD_WIDTH*UNITS;
  localparam int W_WGT = WORD_WIDTH*CORES*MEMBERS;
  localparam int W_PAY = 1 + TUSER_WIDTH + 2*W_PIX + W_WGT;
  logic [W_PAY-1:0]      w_s_pay, r_m, r_s;
  logic                  r_vm, r_vs, r_stall, w_in_fire, w_out_fire;
  logic [BITS_BEATS-1:0] r_cnt, w_cnt_inc;
  assign w_s_pay = {s_axis_tlast, s_axis_tuser, s_pixels_1, s_pixels_2, s_weights};
  assign {m_axis_tlast, m_axis_tuser, m_pixels_1, m_pixels_2, m_weights} = r_m;
  assign s_axis_tready = ~r_vs;
  assign m_axis_tvalid = r_vm;
  assign w_in_fire     = s_axis_tvalid & ~r_vs;
  assign w_out_fire    = r_vm & m_axis_tready;
  assign w_cnt_inc     = &r_cnt ? r_cnt : r_cnt + 1'b1;
  // Skid entry only ever holds a beat while main is occupied, so vS implies vM.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_vm <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_vm <= r_vs | w_in_fire | (r_vm & ~w_out_fire);
      r_vs <= r_vs ? ~w_out_fire : (r_vm & w_in_fire & ~w_out_fire);
    end
  end
  always_ff @(posedge aclk) begin
    if (r_vs & w_out_fire) r_m <= r_s;
    else if (w_in_fire & (~r_vm | w_out_fire)) r_m <= w_s_pay;
    if (w_in_fire & r_vm & ~w_out_fire) r_s <= w_s_pay;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cnt          <= '0;
      frame_beats    <= '0;
      frame_done     <= 1'b0;
      cfg_kernel_w_1 <= '0;
      r_stall        <= 1'b0;
      err_valid_drop <= 1'b0;
    end else begin
      frame_done <= w_out_fire & m_axis_tlast;
      if (w_out_fire) begin
        r_cnt <= m_axis_tlast ? '0 : w_cnt_inc;
        if (m_axis_tlast) frame_beats <= w_cnt_inc;
      end
      if (w_in_fire & s_axis_tuser[I_IS_CONFIG]) cfg_kernel_w_1 <= s_axis_tuser[I_KERNEL_W_1 +: BITS_KERNEL_W];
      r_stall        <= s_axis_tvalid & ~s_axis_tready;
      err_valid_drop <= err_valid_drop | (r_stall & ~s_axis_tvalid);
    end
  end
endmodule

// File: tb/tb_axis_conv_input_slice.sv
// tb_axis_conv_input_slice: directed and random checks of the conv input slice against a queue model
module tb_axis_conv_input_slice;
  localparam int PW = 529;
  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [PW-1:0] s_pay = '0;
  logic          s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_done, err_valid_drop;
  logic [15:0]   m_axis_tuser;
  logic [63:0]   m_pixels_1, m_pixels_2;
  logic [383:0]  m_weights;
  logic [1:0]    cfg_kernel_w_1;
  logic [19:0]   frame_beats;
  logic [PW-1:0] m_pay;
  int            total = 0;
  int            bad = 0;
  logic [PW-1:0] q[$];
  logic [19:0]   x_cnt, x_fb;
  logic [1:0]    x_cfg;
  logic          x_fd, x_err, x_prev;
  int            acc;
  always #5 aclk = ~aclk;
  assign m_pay = {m_axis_tlast, m_axis_tuser, m_pixels_1, m_pixels_2, m_weights};
  axis_conv_input_slice dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_pay[528]), .s_axis_tuser(s_pay[527:512]),
    .s_pixels_1(s_pay[511:448]), .s_pixels_2(s_pay[447:384]), .s_weights(s_pay[383:0]),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_pixels_1(m_pixels_1), .m_pixels_2(m_pixels_2), .m_weights(m_weights),
    .cfg_kernel_w_1(cfg_kernel_w_1), .frame_beats(frame_beats),
    .frame_done(frame_done), .err_valid_drop(err_valid_drop)
  );
  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [PW-1:0] rnd(input logic last, input logic cfg);
    logic [PW-1:0] r;
    for (int i = 0; i < PW; i++) r[i] = 1'($urandom);
    r[528] = last;
    r[519] = cfg;
    return r;
  endfunction
  function automatic logic [19:0] sat(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction
  task automatic mreset();
    q.delete();
    x_cnt = '0; x_fb = '0; x_cfg = '0;
    x_fd = 1'b0; x_err = 1'b0; x_prev = 1'b0;
  endtask
  task automatic upd(input logic r, input logic v, input logic rd, input logic [PW-1:0] p);
    logic          rdy0, in_f, out_f;
    logic [PW-1:0] h;
    if (r) begin
      mreset();
      return;
    end
    rdy0  = q.size() < 2;
    in_f  = v && rdy0;
    out_f = q.size() > 0 && rd;
    x_fd  = 1'b0;
    if (out_f) begin
      h = q.pop_front();
      if (h[528]) begin
        x_fb = sat(x_cnt);
        x_cnt = '0;
        x_fd = 1'b1;
      end else x_cnt = sat(x_cnt);
    end
    x_err  = x_err | (x_prev & !v);
    x_prev = v && !rdy0;
    if (in_f && p[519]) x_cfg = p[525:524];
    if (in_f) begin
      q.push_back(p);
      acc++;
    end
  endtask
  task automatic check_all();
    chk("tready", PW'(s_axis_tready), PW'(q.size() < 2));
    chk("tvalid", PW'(m_axis_tvalid), PW'(q.size() > 0));
    if (q.size() > 0) chk("data", m_pay, q[0]);
    chk("cfg", PW'(cfg_kernel_w_1), PW'(x_cfg));
    chk("frame_beats", PW'(frame_beats), PW'(x_fb));
    chk("frame_done", PW'(frame_done), PW'(x_fd));
    chk("err", PW'(err_valid_drop), PW'(x_err));
  endtask
  task automatic cyc(input logic r, input logic v, input logic rd, input logic [PW-1:0] p);
    areset = r; s_axis_tvalid = v; m_axis_tready = rd; s_pay = p;
    #1 chk("tready_comb", PW'(s_axis_tready), PW'(q.size() < 2));
    @(posedge aclk);
    upd(r, v, rd, p);
    @(negedge aclk);
    check_all();
  endtask
  initial begin
    logic [PW-1:0] p;
    int            n;
    repeat (2) @(posedge aclk);
    mreset();
    @(negedge aclk);
    areset = 1'b0;
    check_all();
    // 16-beat frame at full rate
    for (int i = 1; i <= 16; i++) cyc(0, 1, 1, rnd(i == 16, 0));
    repeat (3) cyc(0, 0, 1, rnd(0, 0));
    chk("t1_frame_beats", PW'(frame_beats), PW'(20'd16));
    // stall with three beats pending, then release
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, rnd(0, 0));
    chk("t2_tready_low", PW'(s_axis_tready), PW'(1'b0));
    p = rnd(1, 0);
    repeat (2) cyc(0, 1, 0, p);
    repeat (2) cyc(0, 1, 1, p);
    repeat (3) cyc(0, 0, 1, rnd(0, 0));
    // config beat followed by normal beats
    p = rnd(0, 1);
    p[525:524] = 2'd2;
    cyc(0, 1, 1, p);
    chk("t4_cfg", PW'(cfg_kernel_w_1), PW'(2'd2));
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, rnd(i == 3, 0));
    chk("t4_cfg_hold", PW'(cfg_kernel_w_1), PW'(2'd2));
    // random traffic
    acc = 0;
    n = 0;
    while (acc < 1000 && n < 8000) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0));
      n++;
    end
    chk("t3_budget", PW'(acc >= 1000), PW'(1'b1));
    repeat (4) cyc(0, 0, 1, rnd(0, 0));
    // reset with both entries full
    cyc(0, 1, 0, rnd(0, 0));
    cyc(0, 1, 0, rnd(0, 0));
    cyc(0, 1, 0, rnd(0, 0));
    cyc(1, 0, 0, rnd(0, 0));
    chk("t5_tvalid", PW'(m_axis_tvalid), PW'(1'b0));
    chk("t5_tready", PW'(s_axis_tready), PW'(1'b1));
    chk("t5_fb", PW'(frame_beats), PW'(20'd0));
    for (int i = 1; i <= 3; i++) cyc(0, 1, 1, rnd(i == 3, 0));
    repeat (2) cyc(0, 0, 1, rnd(0, 0));
    chk("t5_fb_after", PW'(frame_beats), PW'(20'd3));
    // valid withdrawn during stall
    chk("t6_err_clear", PW'(err_valid_drop), PW'(1'b0));
    repeat (3) cyc(0, 1, 0, rnd(0, 0));
    cyc(0, 0, 0, rnd(0, 0));
    repeat (4) cyc(0, 0, 1, rnd(0, 0));
    chk("t6_err_set", PW'(err_valid_drop), PW'(1'b1));
    cyc(1, 0, 0, rnd(0, 0));
    chk("t6_err_reset", PW'(err_valid_drop), PW'(1'b0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
